argmax_stream: RTL and testbench

- Streaming, parametrised argmax unit for the FNN output layer.
- Accepts NUM_CLASSES scores over several beats, LANES scores per beat, through a valid/ready handshake.
- Tracks the running maximum and returns the winning class index and its score.
- Sits between the final neuron layer and the classification result register. Replaces the fixed 10-class, 8-bit, purely combinational selector.

---
 rtl/argmax_stream.sv | 173 +++++++++++++++++
 tb/tb_argmax_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/argmax_stream.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_stream
//  Description : Streaming argmax for the FNN output layer. Accepts a vector
//                of NUM_CLASSES scores over BEATS = ceil(NUM_CLASSES/LANES)
//                beats (LANES scores per beat) through a valid/ready
//                handshake. It tracks the running maximum and presents the
//                winning class index and score. On ties, the lowest class
//                index wins.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-high reset
//                in_data    - LANES scores; lane k at [k*DATA_W +: DATA_W]
//                in_valid   - input beat valid
//                in_ready   - block can accept a beat (low while result held)
//                out_idx    - winning class index
//                out_max    - winning score
//                out_valid  - result valid
//                out_ready  - consumer accepts the result
//  Options     : `define ARGMAX_SIGNED_EN -> scores are two's-complement
//                and all comparisons are signed. Default is unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_stream #(
    parameter int DATA_W      = 8,
    parameter int NUM_CLASSES = 10,
    parameter int LANES       = 2,
    parameter int IDX_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic [DATA_W-1:0]         out_max,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [IDX_W-1:0]   r_best_idx;
    logic [DATA_W-1:0]  r_best_val;

    logic [DATA_W-1:0]  w_win_val;
    int                 w_win_lane;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_accept;
    logic               w_load;
    logic               w_update;
    logic               w_cnt_inc;
    logic               w_cnt_clr;

    // Strict greater-than in the configured number format.
    function automatic logic f_gt(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Beat winner. Lane 0 is always a real class, so it seeds the search.
    // Higher lanes replace it only when strictly greater, which keeps the
    // lowest lane on ties. Padding lanes of the last beat are skipped.
    always_comb begin
        w_win_val  = in_data[0 +: DATA_W];
        w_win_lane = 0;
        for (int k = 1; k < LANES; k++) begin
            if (((int'(r_beat_cnt) * LANES + k) < NUM_CLASSES) &&
                f_gt(in_data[k*DATA_W +: DATA_W], w_win_val)) begin
                w_win_val  = in_data[k*DATA_W +: DATA_W];
                w_win_lane = k;
            end
        end
    end

    assign w_win_idx = IDX_W'(int'(r_beat_cnt) * LANES + w_win_lane);
    assign w_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_update    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        in_ready    = 1'b1;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = (BEATS == 1) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    // Strict compare: a later equal score never displaces
                    // the earlier, lower class index.
                    w_update  = f_gt(w_win_val, r_best_val);
                    w_cnt_inc = 1'b1;
                    if (r_beat_cnt == C_LAST_BEAT) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: beat counter and running best
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_beat_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_load || w_update) begin
                r_best_idx <= w_win_idx;
                r_best_val <= w_win_val;
            end
        end
    end

    assign out_idx = r_best_idx;
    assign out_max = r_best_val;

endmodule
`default_nettype wire

// File: tb/tb_argmax_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_stream
//  Description : Directed bench for argmax_stream. Instance A uses
//                N=10/L=2 and instance B uses N=10/L=3, with shared clk/rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] a_data  = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [3:0]  a_idx;
    logic [7:0]  a_max;
    logic        a_ovalid;
    logic        a_oready = 1'b0;

    logic [23:0] b_data  = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [3:0]  b_idx;
    logic [7:0]  b_max;
    logic        b_ovalid;
    logic        b_oready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    argmax_stream #(.DATA_W(8), .NUM_CLASSES(10), .LANES(2), .IDX_W(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_idx(a_idx), .out_max(a_max), .out_valid(a_ovalid), .out_ready(a_oready)
    );

    argmax_stream #(.DATA_W(8), .NUM_CLASSES(10), .LANES(3), .IDX_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .out_idx(b_idx), .out_max(b_max), .out_valid(b_ovalid), .out_ready(b_oready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] l0, input logic [7:0] l1);
        a_data  = {l1, l0};
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        b_data  = {l2, l1, l0};
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic consume_a();
        a_oready = 1'b1;
        tick();
        a_oready = 1'b0;
        chk("a_consume_ovalid", a_ovalid, 0);
        chk("a_consume_iready", a_ready, 1);
    endtask

    task automatic consume_b();
        b_oready = 1'b1;
        tick();
        b_oready = 1'b0;
        chk("b_consume_ovalid", b_ovalid, 0);
        chk("b_consume_iready", b_ready, 1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk("rst_a_iready", a_ready, 1);
        chk("rst_a_ovalid", a_ovalid, 0);
        chk("rst_a_idx", a_idx, 0);
        chk("rst_a_max", a_max, 0);
        chk("rst_b_iready", b_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- 1: ties, back-to-back ----------------
        send_a(8'd3, 8'd9);
        send_a(8'd1, 8'd9);
        send_a(8'd0, 8'd0);
        send_a(8'd0, 8'd0);
        chk("t1_ovalid_early", a_ovalid, 0);
        send_a(8'd0, 8'd9);
        chk("t1_ovalid", a_ovalid, 1);
        chk("t1_idx", a_idx, 1);
        chk("t1_max", a_max, 9);
        chk("t1_iready", a_ready, 0);
        consume_a();

        // ---------------- 2: padding lanes ignored (L=3) ----------------
        send_b(8'd10, 8'd40, 8'd3);
        send_b(8'd40, 8'd7, 8'd8);
        send_b(8'd1, 8'd2, 8'd40);
        chk("t2_ovalid_early", b_ovalid, 0);
        send_b(8'd50, 8'd255, 8'd255);
        chk("t2_ovalid", b_ovalid, 1);
        chk("t2_idx", b_idx, 9);
        chk("t2_max", b_max, 50);
        consume_b();
        // class 9 is small; 40 at classes 1,3,8 -> lowest index
        send_b(8'd10, 8'd40, 8'd3);
        send_b(8'd40, 8'd7, 8'd8);
        send_b(8'd1, 8'd2, 8'd40);
        send_b(8'd5, 8'd255, 8'd255);
        chk("t2b_idx", b_idx, 1);
        chk("t2b_max", b_max, 40);
        consume_b();

        // ---------------- 3: backpressure ----------------
        send_a(8'd10, 8'd20);
        send_a(8'd30, 8'd40);
        send_a(8'd200, 8'd5);
        send_a(8'd199, 8'd0);
        send_a(8'd200, 8'd7);
        // Junk beat presented while the result is held must not be taken.
        a_data  = {8'd255, 8'd255};
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_ovalid", a_ovalid, 1);
            chk("t3_hold_iready", a_ready, 0);
`ifdef ARGMAX_SIGNED_EN
            chk("t3_hold_idx", a_idx, 3);
            chk("t3_hold_max", a_max, 40);
`else
            chk("t3_hold_idx", a_idx, 4);
            chk("t3_hold_max", a_max, 200);
`endif
            tick();
        end
        a_valid = 1'b0;
        consume_a();

        // ---------------- 4: reset mid-vector ----------------
        send_a(8'd250, 8'd1);
        send_a(8'd2, 8'd3);
        rst = 1'b1;
        #1;
        chk("t4_rst_idx", a_idx, 0);
        chk("t4_rst_max", a_max, 0);
        chk("t4_rst_ovalid", a_ovalid, 0);
        tick();
        rst = 1'b0;
        tick();
        send_a(8'd0, 8'd1);
        send_a(8'd2, 8'd3);
        send_a(8'd4, 8'd5);
        send_a(8'd7, 8'd6);
        chk("t4_ovalid_early", a_ovalid, 0);
        send_a(8'd1, 8'd2);
        chk("t4_ovalid", a_ovalid, 1);
        chk("t4_idx", a_idx, 6);
        chk("t4_max", a_max, 7);
        consume_a();

        // ---------------- 5: gapped input ----------------
        send_a(8'd1, 8'd2);
        tick(); tick();
        send_a(8'd3, 8'd4);
        tick(); tick();
        send_a(8'd5, 8'd6);
        tick(); tick();
        send_a(8'd7, 8'd8);
        tick(); tick();
        chk("t5_ovalid_gap", a_ovalid, 0);
        chk("t5_iready_gap", a_ready, 1);
        send_a(8'd100, 8'd99);
        chk("t5_ovalid", a_ovalid, 1);
        chk("t5_idx", a_idx, 8);
        chk("t5_max", a_max, 100);
        consume_a();

        // ---------------- 6: signedness ----------------
        send_a(8'h00, 8'h00);
        send_a(8'h80, 8'h00);
        send_a(8'h00, 8'h01);
        send_a(8'h00, 8'h00);
        send_a(8'h00, 8'h00);
        chk("t6_ovalid", a_ovalid, 1);
`ifdef ARGMAX_SIGNED_EN
        chk("t6_idx", a_idx, 5);
        chk("t6_max", a_max, 8'h01);
`else
        chk("t6_idx", a_idx, 2);
        chk("t6_max", a_max, 8'h80);
`endif
        consume_a();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
